// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the multiplexed-bus RTC burst master.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_HOLD,
    S_DATA,
    S_DATA_HOLD,
    S_GAP
  } state_e;

  typedef struct packed {
    logic ad;
    logic cs;
    logic rd;
    logic wr;
    logic oe;
  } pins_t;

  // Strobe/enable levels for each bus phase; idle is also the reset level.
  localparam pins_t PINS_IDLE      = '{ad: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, oe: 1'b0};
  localparam pins_t PINS_ADDR      = '{ad: 1'b0, cs: 1'b0, rd: 1'b1, wr: 1'b0, oe: 1'b1};
  localparam pins_t PINS_ADDR_HOLD = '{ad: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, oe: 1'b1};
  localparam pins_t PINS_DATA_WR   = '{ad: 1'b1, cs: 1'b0, rd: 1'b1, wr: 1'b0, oe: 1'b1};
  localparam pins_t PINS_DATA_RD   = '{ad: 1'b1, cs: 1'b0, rd: 1'b0, wr: 1'b1, oe: 1'b0};
  localparam pins_t PINS_HOLD_WR   = '{ad: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, oe: 1'b1};
  localparam pins_t PINS_HOLD_RD   = '{ad: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, oe: 1'b0};

  localparam int IDX_W = 4;

  function automatic int phase_cnt_width(input int phase_cycles);
    return (phase_cycles > 1) ? $clog2(phase_cycles) : 1;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase down-counter: reloads on every state entry, phase_end_o marks the last
// cycle of the current bus phase.
module rtc_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic active_i,
  output logic phase_end_o
);

  localparam int CNT_W = phase_cnt_width(PHASE_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PHASE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = active_i && (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_master.sv
// Burst bus-cycle generator for multiplexed AD/CS/RD/WR RTC chips.
// Read-back bursts are built only when RTC_BUS_READBACK_EN is defined.
module rtc_bus_master
  import rtc_bus_pkg::*;
#(
  parameter int          NUM_REGS     = 6,
  parameter logic [7:0]  ADDR_BASE    = 8'h21,
  parameter int          PHASE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rw,
  input  logic [8*NUM_REGS-1:0] wr_data,
  output logic [8*NUM_REGS-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  AD,
  output logic                  CS,
  output logic                  RD,
  output logic                  WR,
  output logic [7:0]            bus_out,
  output logic                  bus_oe,
  input  logic [7:0]            bus_in
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_e                state_q;
  pins_t                 pins_q;
  logic [7:0]            bus_out_q;
  logic                  busy_q, done_q, rw_q;
  logic [8*NUM_REGS-1:0] wdata_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  phase_end, rw_sel, accept;

`ifdef RTC_BUS_READBACK_EN
  assign rw_sel = rw;
`else
  assign rw_sel = 1'b0;
`endif

  // The done cycle is still treated as busy for start requests.
  assign accept = (state_q == S_IDLE) && start && !done_q;

  rtc_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load_i      ((state_q == S_IDLE) || phase_end),
    .active_i    (state_q != S_IDLE),
    .phase_end_o (phase_end)
  );

  // Pin levels are registered together with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pins_q    <= PINS_IDLE;
      bus_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rw_q      <= 1'b0;
      // NOTE: the write-data latch is a plain register bank, so it is reset like any other flop.
      wdata_q   <= '0;
      idx_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          state_q   <= S_ADDR;
          pins_q    <= PINS_ADDR;
          bus_out_q <= ADDR_BASE;
          busy_q    <= 1'b1;
          rw_q      <= rw_sel;
          wdata_q   <= wr_data;
          idx_q     <= '0;
        end
        S_ADDR: if (phase_end) begin
          state_q <= S_ADDR_HOLD;
          pins_q  <= PINS_ADDR_HOLD;
        end
        S_ADDR_HOLD: if (phase_end) begin
          state_q   <= S_DATA;
          pins_q    <= rw_q ? PINS_DATA_RD : PINS_DATA_WR;
          bus_out_q <= rw_q ? 8'h00 : wdata_q[{idx_q, 3'b000} +: 8];
        end
        S_DATA: if (phase_end) begin
          state_q <= S_DATA_HOLD;
          pins_q  <= rw_q ? PINS_HOLD_RD : PINS_HOLD_WR;
        end
        S_DATA_HOLD: if (phase_end) begin
          state_q   <= S_GAP;
          pins_q    <= PINS_IDLE;
          bus_out_q <= '0;
        end
        S_GAP: if (phase_end) begin
          if (idx_q != LAST_IDX) begin
            idx_q     <= idx_q + IDX_W'(1);
            state_q   <= S_ADDR;
            pins_q    <= PINS_ADDR;
            bus_out_q <= ADDR_BASE + 8'(idx_q) + 8'd1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          pins_q    <= PINS_IDLE;
          bus_out_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef RTC_BUS_READBACK_EN
  logic [8*NUM_REGS-1:0] rd_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if ((state_q == S_DATA) && phase_end && rw_q) begin
      rd_data_q[{idx_q, 3'b000} +: 8] <= bus_in;
    end
  end

  assign rd_data = rd_data_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{rw, bus_in};
  assign rd_data       = '0;
`endif

  assign AD      = pins_q.ad;
  assign CS      = pins_q.cs;
  assign RD      = pins_q.rd;
  assign WR      = pins_q.wr;
  assign bus_oe  = pins_q.oe;
  assign bus_out = bus_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_rtc_bus_master.sv
// Directed bench for rtc_bus_master: default 6-register instance plus two
// single-cycle-phase instances at ADDR_BASE=FF for the wrap corner.
module tb_rtc_bus_master;

`ifdef RTC_BUS_READBACK_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [47:0] wr_data = '0;
  logic [47:0] rd_data;
  logic        busy, done, AD, CS, RD, WR, bus_oe;
  logic [7:0]  bus_out, bus_in;
  logic [7:0]  rtc_addr = 8'h00;

  logic        s_start = 1'b0;
  logic        s_rw = 1'b0;
  logic [7:0]  s_bus_in = 8'h00;
  logic [7:0]  s1_wr = 8'hA5;
  logic [15:0] s2_wr = 16'h5AC3;
  logic [7:0]  s1_rd, s1_bus_out, s2_bus_out;
  logic [15:0] s2_rd;
  logic        s1_busy, s1_done, s1_AD, s1_CS, s1_RD, s1_WR, s1_oe;
  logic        s2_busy, s2_done, s2_AD, s2_CS, s2_RD, s2_WR, s2_oe;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // RTC model: latches the address during the address phase, returns addr XOR FF.
  always @(negedge clk) if (!AD && !CS) rtc_addr <= bus_out;
  assign bus_in = rtc_addr ^ 8'hFF;

  rtc_bus_master dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .wr_data(wr_data), .rd_data(rd_data),
    .busy(busy), .done(done), .AD(AD), .CS(CS), .RD(RD), .WR(WR),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
  );

  rtc_bus_master #(.NUM_REGS(1), .ADDR_BASE(8'hFF), .PHASE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst(rst), .start(s_start), .rw(s_rw), .wr_data(s1_wr), .rd_data(s1_rd),
    .busy(s1_busy), .done(s1_done), .AD(s1_AD), .CS(s1_CS), .RD(s1_RD), .WR(s1_WR),
    .bus_out(s1_bus_out), .bus_oe(s1_oe), .bus_in(s_bus_in)
  );

  rtc_bus_master #(.NUM_REGS(2), .ADDR_BASE(8'hFF), .PHASE_CYCLES(1)) dut_s2 (
    .clk(clk), .rst(rst), .start(s_start), .rw(s_rw), .wr_data(s2_wr), .rd_data(s2_rd),
    .busy(s2_busy), .done(s2_done), .AD(s2_AD), .CS(s2_CS), .RD(s2_RD), .WR(s2_WR),
    .bus_out(s2_bus_out), .bus_oe(s2_oe), .bus_in(s_bus_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {busy, AD, CS, RD, WR, bus_oe, bus_out-when-driven} for burst cycle c.
  function automatic logic [13:0] exp_pins(input int c, input bit rd, input logic [47:0] d);
    int         r  = c / 10;
    int         ph = (c % 10) / 2;
    logic [7:0] a  = 8'h21 + 8'(r);
    logic [7:0] b  = d[8*r +: 8];
    case (ph)
      0:       return {1'b1, 5'b00101, a};
      1:       return {1'b1, 5'b11111, a};
      2:       return rd ? {1'b1, 5'b10010, 8'h00} : {1'b1, 5'b10101, b};
      3:       return rd ? {1'b1, 5'b11110, 8'h00} : {1'b1, 5'b11111, b};
      default: return {1'b1, 5'b11110, 8'h00};
    endcase
  endfunction

  task automatic run_burst(input logic rw_in, input logic [47:0] data, input bit exp_read,
                           input bit poke, input string name);
    int   wr_falls  = 0;
    bit   strobe_ok = 1'b1;
    logic prev_wr   = 1'b1;
    rw      = rw_in;
    wr_data = data;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wr_data = ~data;
    for (int c = 0; c < 60; c++) begin
      check($sformatf("%s cyc%0d pins", name, c),
            64'({busy, AD, CS, RD, WR, bus_oe, (bus_oe ? bus_out : 8'h00)}),
            64'(exp_pins(c, exp_read, data)));
      if (prev_wr && !WR) wr_falls++;
      prev_wr = WR;
      if (!RD && (bus_oe || !WR)) strobe_ok = 1'b0;
      start = poke && (c == 7);
      tick();
    end
    check($sformatf("%s done pulse", name), 64'({busy, done}), 64'(2'b01));
    check($sformatf("%s WR falls", name), 64'(wr_falls), exp_read ? 64'd0 : 64'd12);
    check($sformatf("%s strobe overlap", name), 64'(strobe_ok), 64'd1);
    start = poke;
    tick();
    start = 1'b0;
    check($sformatf("%s idle after done", name), 64'({busy, done}), 64'(2'b00));
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("reset pins", 64'({AD, CS, RD, WR, bus_oe}), 64'(5'b11110));
    check("reset busy/done", 64'({busy, done}), 64'(2'b00));
    check("reset bus_out", 64'(bus_out), 64'h0);
    check("reset rd_data", 64'(rd_data), 64'h0);
    rst = 1'b1;
    tick();

    // Default write burst; extra starts during busy and in the done cycle are ignored
    run_burst(1'b0, 48'h16_12_15_10_23_12, 1'b0, 1'b1, "wr");
    check("rd_data after write", 64'(rd_data), 64'h0);

    // Burst accepted in the first idle cycle after done; read if built, else write
    run_burst(1'b1, 48'h66_55_44_33_22_11, READ_EN, 1'b0, "rw1");
    check("rd_data after rw=1 burst", 64'(rd_data), READ_EN ? 64'h00_00_D9_DA_DB_DC_DD_DE : 64'h0);

    // Asynchronous reset in the middle of a DATA phase
    rw = 1'b1; wr_data = 48'hAA_BB_CC_DD_EE_FF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("mid-DATA CS low", 64'({busy, CS}), 64'(2'b10));
    #2 rst = 1'b0;
    #1;
    check("async reset pins", 64'({AD, CS, RD, WR, bus_oe, bus_out}), 64'({5'b11110, 8'h00}));
    check("async reset busy/done", 64'({busy, done}), 64'(2'b00));
    check("async reset rd_data", 64'(rd_data), 64'h0);
    tick();
    rst = 1'b1;
    tick();

    // Corner instances: one/two registers, single-cycle phases, base FF wrapping to 00
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) begin
        check("s1 addr FF", 64'({s1_busy, s1_AD, s1_CS, s1_WR, s1_oe, s1_bus_out}), 64'({5'b10001, 8'hFF}));
        check("s2 addr FF", 64'({s2_busy, s2_AD, s2_oe, s2_bus_out}), 64'({3'b101, 8'hFF}));
      end
      if (c == 2) check("s1 data", 64'({s1_CS, s1_WR, s1_oe, s1_bus_out}), 64'({3'b001, 8'hA5}));
      if (c == 4) check("s1 last busy", 64'({s1_busy, s1_done}), 64'(2'b10));
      if (c == 5) begin
        check("s1 done", 64'({s1_busy, s1_done}), 64'(2'b01));
        check("s2 addr wraps", 64'({s2_busy, s2_AD, s2_oe, s2_bus_out}), 64'({3'b101, 8'h00}));
      end
      if (c == 7) check("s2 data byte1", 64'({s2_WR, s2_bus_out}), 64'({1'b0, 8'h5A}));
      if (c == 9) check("s2 last busy", 64'({s2_busy, s2_done}), 64'(2'b10));
      if (c == 10) check("s2 done", 64'({s2_busy, s2_done, s1_done}), 64'(3'b010));
      tick();
    end
    check("corner rd_data", 64'({s1_rd, s2_rd}), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
